perf_event_monitor: RTL and testbench
=====================================

Name: perf_event_monitor

Overview:
- In-processor event producer and summariser: counts retired instructions, cycles, and I/D-cache requests and hits.
- On halt, it freezes the counters and streams a fixed six-word summary record over a valid/ready interface, for a trace unit or host reader.
- Instantiated inside proc beside the memory/writeback stages.
- Its event inputs are the same qualified retire and cache strobes the pipeline already produces.

Parameters:
- CNT_W, 32: width of every counter and of dump_data.
- NUM_CNT, 6: number of counters and summary words; fixed record length, not user-tunable.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ev_regwrite  input  1  a register-file write retires this cycle.
- ev_memwrite  input  1  a data-memory write completes this cycle.
- ev_halt  input  1  HALT has reached writeback; single-cycle pulse.
- ev_icache_req  input  1  valid instruction-cache request this cycle.
- ev_icache_hit  input  1  instruction-cache hit this cycle.
- ev_dcache_req  input  1  valid data-cache read or write request this cycle.
- ev_dcache_hit  input  1  data-cache hit this cycle.
- dump_valid  output  1  a summary word is presented.
- dump_ready  input  1  the consumer accepts the word.
- dump_id  output  3  counter index of the presented word.
- dump_data  output  CNT_W  counter value of the presented word.
- done  output  1  the whole summary has been accepted; sticky.

Behaviour:
- Reset:
  - all counters = 0, state = COUNT.
  - dump_valid = 0, dump_id = 0, dump_data = 0, done = 0.
  - rst wins over every other input, in any state, including mid-dump.
- Counter map (ids):
  - 0 cycles.
  - 1 inst.
  - 2 icache_req.
  - 3 icache_hit.
  - 4 dcache_req.
  - 5 dcache_hit.
- Update rules in COUNT, each cycle:
  - cycles += 1.
  - inst += 1 if (ev_halt | ev_regwrite | ev_memwrite); at most 1 per cycle.
  - icache_req += ev_icache_req.
  - icache_hit += (ev_icache_hit & ev_icache_req); a hit with no request is ignored.
  - dcache_req and dcache_hit follow the same rule as the I-cache pair.
- Saturation: each counter stops at 2^CNT_W-1 and never wraps.
- Halt cycle: all events present in the ev_halt cycle, and the cycle itself, are counted. The next state is DUMP with index 0.
- FSM states:
  - COUNT: counting as above; COUNT -> DUMP on ev_halt.
  - DUMP:
    - Counters frozen; all ev_* ignored.
    - dump_valid = 1, dump_id = idx, dump_data = counter[idx].
    - On dump_valid & dump_ready: idx += 1.
    - If the accepted word has idx == 5, go to DONE.
    - dump_id and dump_data hold stable while valid & ~ready.
  - DONE: dump_valid = 0, done = 1, ev_* ignored. Exit only by rst.
- Latency: the first word is valid the cycle after the ev_halt edge. With ready held high, six words go out in 6 consecutive cycles and done rises 7 cycles after the halt edge.
- A second ev_halt in DUMP or DONE has no effect.
- dump_valid never drops without a handshake.

Decomposition:
- Shared package perf_pkg:
  - counter-id constants CNT_CYCLES..CNT_DHIT (0..5).
  - NUM_CNT.
  - state encoding ST_COUNT/ST_DUMP/ST_DONE.
- One sub-module, sat_counter: parameter W; ports clk, rst, inc, en, q. It saturates at all-ones. It is instantiated six times.
- FSM, index and output mux stay in the top.

Test Plan:
- Reset then idle: 10 cycles with no events, then ev_halt.
  - Required: words (0,11), (1,1), (2,0), (3,0), (4,0), (5,0), in that order.
  - done = 1 after the sixth handshake.
- Mixed events over 20 cycles:
  - Stimulus: regwrite on 8 cycles, memwrite on 3 of them overlapping plus 2 alone; icache_req on all 20 with 15 hits; dcache_req on 5 with 4 hits, plus 2 hit-without-req cycles; halt on cycle 20 together with regwrite.
  - Required: cycles=20, inst=10, ireq=20, ihit=15, dreq=5, dhit=4.
- Backpressure: ready low for 3 cycles on word 2, then toggled 1/0.
  - Required: dump_id/dump_data stable while stalled.
  - Required: no word skipped or repeated; done only after id 5 is accepted.
- Saturation with CNT_W=4: 20 cycles with icache_req high, then halt.
  - Required: cycles = 15 and ireq = 15 (no wrap).
- Reset mid-dump: rst asserted after word 2 is accepted.
  - Required next cycle: dump_valid = 0, done = 0, all counters 0.
  - Then 5 idle cycles and halt must report cycles = 6.
- Post-halt events: ev_* and a second ev_halt toggled during DUMP and DONE.
  - Required: reported values identical to the first halt's snapshot; no restart of the dump.

Source files
------------

// File: rtl/perf_pkg.sv
// perf_pkg: shared counter ids, record length and FSM encoding for perf_event_monitor.
package perf_pkg;
    localparam int NUM_CNT    = 6;
    localparam int CNT_CYCLES = 0;
    localparam int CNT_INST   = 1;
    localparam int CNT_IREQ   = 2;
    localparam int CNT_IHIT   = 3;
    localparam int CNT_DREQ   = 4;
    localparam int CNT_DHIT   = 5;
    typedef enum logic [1:0] {ST_COUNT, ST_DUMP, ST_DONE} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
// Ports: clk, rst (sync, active-high), inc (count request), en (counting allowed), q (value).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         en,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (en && inc && q != '1) q <= q + 1'b1;
    end
endmodule

// File: rtl/perf_event_monitor.sv
// perf_event_monitor: counts cycles, retired instructions and I/D-cache requests/hits,
// then on halt freezes the counters and streams a six-word summary over valid/ready.
// Ports: clk, rst (sync, active-high); ev_* qualified pipeline event strobes;
// dump_valid/dump_ready/dump_id/dump_data summary stream; done sticky completion flag.
module perf_event_monitor
    import perf_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ev_regwrite,
    input  logic             ev_memwrite,
    input  logic             ev_halt,
    input  logic             ev_icache_req,
    input  logic             ev_icache_hit,
    input  logic             ev_dcache_req,
    input  logic             ev_dcache_hit,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [2:0]       dump_id,
    output logic [CNT_W-1:0] dump_data,
    output logic             done
);
    state_t             state;
    logic [2:0]         idx;
    logic [NUM_CNT-1:0] inc;
    logic [CNT_W-1:0]   cnt [NUM_CNT];

    // A hit only counts when it accompanies a request.
    assign inc[CNT_CYCLES] = 1'b1;
    assign inc[CNT_INST]   = ev_halt | ev_regwrite | ev_memwrite;
    assign inc[CNT_IREQ]   = ev_icache_req;
    assign inc[CNT_IHIT]   = ev_icache_hit & ev_icache_req;
    assign inc[CNT_DREQ]   = ev_dcache_req;
    assign inc[CNT_DHIT]   = ev_dcache_hit & ev_dcache_req;

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc[i]),
            .en  (state == ST_COUNT),
            .q   (cnt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_COUNT;
            idx        <= '0;
            dump_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_COUNT: if (ev_halt) begin
                    state      <= ST_DUMP;
                    idx        <= '0;
                    dump_valid <= 1'b1;
                end
                ST_DUMP: if (dump_ready) begin
                    if (idx == 3'(NUM_CNT - 1)) begin
                        state      <= ST_DONE;
                        dump_valid <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Counters are frozen outside COUNT, so the mux output is stable while stalled.
    assign dump_id   = idx;
    assign dump_data = dump_valid ? cnt[idx] : '0;
endmodule

// File: tb/tb_perf_event_monitor.sv
// tb_perf_event_monitor: directed stimulus for a 32-bit and a 4-bit (saturating) monitor,
// checked every cycle against a behavioural model plus literal summary records.
module tb_perf_event_monitor;
    typedef longint rec_t [6];

    logic clk = 0, rst = 1, dump_ready = 1;
    logic rw = 0, mw = 0, halt = 0, ir = 0, ih = 0, dr = 0, dh = 0;
    logic v32, d32, v4, d4;
    logic [2:0] id32, id4;
    logic [31:0] dat32;
    logic [3:0] dat4;

    int checks = 0, errors = 0;
    longint m_cnt [6] = '{default: 0};
    int m_phase = 0, m_idx = 0;
    bit armed = 0;
    int q_id32[$], q_id4[$];
    longint q_d32[$], q_d4[$];

    always #5 clk = ~clk;

    perf_event_monitor #(.CNT_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .ev_regwrite(rw), .ev_memwrite(mw), .ev_halt(halt),
        .ev_icache_req(ir), .ev_icache_hit(ih), .ev_dcache_req(dr), .ev_dcache_hit(dh),
        .dump_valid(v32), .dump_ready(dump_ready), .dump_id(id32), .dump_data(dat32), .done(d32)
    );

    perf_event_monitor #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .ev_regwrite(rw), .ev_memwrite(mw), .ev_halt(halt),
        .ev_icache_req(ir), .ev_icache_hit(ih), .ev_dcache_req(dr), .ev_dcache_hit(dh),
        .dump_valid(v4), .dump_ready(dump_ready), .dump_id(id4), .dump_data(dat4), .done(d4)
    );

    function automatic longint sat(input longint v, input int w);
        longint mx = (64'sd1 <<< w) - 1;
        return v > mx ? mx : v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: unbounded event tallies; saturation applied only when predicting outputs.
    always @(posedge clk) begin
        if (rst) begin
            foreach (m_cnt[k]) m_cnt[k] <= 0;
            m_phase <= 0;
            m_idx   <= 0;
            armed   <= 1;
        end else if (m_phase == 0) begin
            m_cnt[0] <= m_cnt[0] + 1;
            if (halt || rw || mw) m_cnt[1] <= m_cnt[1] + 1;
            if (ir)       m_cnt[2] <= m_cnt[2] + 1;
            if (ir && ih) m_cnt[3] <= m_cnt[3] + 1;
            if (dr)       m_cnt[4] <= m_cnt[4] + 1;
            if (dr && dh) m_cnt[5] <= m_cnt[5] + 1;
            if (halt) begin
                m_phase <= 1;
                m_idx   <= 0;
            end
        end else if (m_phase == 1 && dump_ready) begin
            if (m_idx == 5) m_phase <= 2;
            else m_idx <= m_idx + 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("valid32", v32, m_phase == 1);
            check("done32", d32, m_phase == 2);
            check("valid4", v4, m_phase == 1);
            check("done4", d4, m_phase == 2);
            if (m_phase == 1) begin
                check("id32", id32, m_idx);
                check("data32", dat32, sat(m_cnt[m_idx], 32));
                check("id4", id4, m_idx);
                check("data4", dat4, sat(m_cnt[m_idx], 4));
            end
        end
        if (v32 === 1'b1 && dump_ready) begin
            q_id32.push_back(int'(id32));
            q_d32.push_back(longint'(dat32));
        end
        if (v4 === 1'b1 && dump_ready) begin
            q_id4.push_back(int'(id4));
            q_d4.push_back(longint'(dat4));
        end
    end

    task automatic drive(input logic [6:0] e);
        {rw, mw, halt, ir, ih, dr, dh} = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1;
        {rw, mw, halt, ir, ih, dr, dh} = '0;
        dump_ready = 1;
        @(posedge clk);
        #1;
        check({tag, "_rst_valid"}, v32 | v4, 0);
        check({tag, "_rst_done"}, d32 | d4, 0);
        check({tag, "_rst_id"}, id32 | id4, 0);
        check({tag, "_rst_data32"}, dat32, 0);
        check({tag, "_rst_data4"}, dat4, 0);
        rst = 0;
        q_id32.delete(); q_d32.delete(); q_id4.delete(); q_d4.delete();
    endtask

    task automatic run_dump(input logic [15:0] pat, input bit noise);
        for (int i = 0; i < 40; i++) begin
            dump_ready = i < 16 ? pat[i] : 1'b1;
            drive(noise ? 7'($urandom) : 7'd0);
            if (d32 && d4) break;
        end
        check("done_reached", d32 && d4, 1);
        {rw, mw, halt, ir, ih, dr, dh} = '0;
        dump_ready = 1;
    endtask

    task automatic check_words(input string tag, input rec_t e32, input rec_t e4);
        check({tag, "_nwords32"}, q_id32.size(), 6);
        check({tag, "_nwords4"}, q_id4.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < q_id32.size()) begin
                check({tag, "_wid32"}, q_id32[k], k);
                check({tag, "_wdata32"}, q_d32[k], e32[k]);
            end
            if (k < q_id4.size()) begin
                check({tag, "_wid4"}, q_id4[k], k);
                check({tag, "_wdata4"}, q_d4[k], e4[k]);
            end
        end
    endtask

    localparam logic [6:0] E_HALT = 7'b0010000;

    initial begin
        do_reset("idle");
        repeat (10) drive('0);
        drive(E_HALT);
        run_dump(16'hFFFF, 0);
        check_words("idle", '{11, 1, 0, 0, 0, 0}, '{11, 1, 0, 0, 0, 0});

        do_reset("mixed");
        for (int k = 1; k <= 20; k++)
            drive({k <= 7 || k == 20, k <= 3 || k == 10 || k == 11, k == 20, 1'b1,
                   k <= 15, k <= 5, k <= 4 || k == 8 || k == 9});
        run_dump(16'hFFFF, 0);
        check_words("mixed", '{20, 10, 20, 15, 5, 4}, '{15, 10, 15, 15, 5, 4});

        do_reset("bp");
        repeat (3) drive('0);
        drive(E_HALT);
        run_dump(16'h0AA3, 0);
        check_words("bp", '{4, 1, 0, 0, 0, 0}, '{4, 1, 0, 0, 0, 0});

        do_reset("sat");
        repeat (20) drive(7'b0001000);
        drive(E_HALT);
        run_dump(16'hFFFF, 0);
        check_words("sat", '{21, 1, 20, 0, 0, 0}, '{15, 1, 15, 0, 0, 0});

        do_reset("mid");
        repeat (2) drive(7'b1000000);
        drive(E_HALT);
        repeat (3) drive('0);
        check("mid_words_before_rst", q_id32.size(), 3);
        do_reset("mid2");
        repeat (5) drive('0);
        drive(E_HALT);
        run_dump(16'hFFFF, 0);
        check_words("mid", '{6, 1, 0, 0, 0, 0}, '{6, 1, 0, 0, 0, 0});

        do_reset("post");
        repeat (3) drive(7'b1001100);
        drive(E_HALT);
        run_dump(16'h5555, 1);
        repeat (10) drive(7'($urandom) | E_HALT);
        drive('0);
        check("post_done_held", d32 && d4, 1);
        check_words("post", '{4, 4, 3, 3, 0, 0}, '{4, 4, 3, 3, 0, 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
